// File: rtl/if_stage.sv
// Instruction-fetch stage: pre-IF nextpc selection, SRAM request, IF register.
// One-cycle SRAM read; IF holds its instruction while decode withholds allowin.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [33:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        br_stall;
  logic        br_taken;
  logic [31:0] br_target;

  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] inst_buf;
  logic        inst_buf_valid;
  logic [31:0] br_buf_target;
  logic        br_buf_valid;

  logic        fs_allowin;
  logic        issue;
  logic        redirect;
  logic [31:0] seq_pc;
  logic [31:0] nextpc_raw;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;

  assign br_stall  = br_bus[33];
  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  assign fs_allowin = ~fs_valid | ds_allowin;
  assign issue      = ~reset & fs_allowin & ~br_stall;
  // fs_valid means the delay slot sits in IF, so decode's target is trustworthy
  assign redirect   = br_taken & ~br_stall & fs_valid;
  assign seq_pc     = fs_pc + 32'd4;

  always_comb begin
    nextpc_raw = seq_pc;
    if (br_buf_valid)  nextpc_raw = br_buf_target;
    else if (redirect) nextpc_raw = br_target;
  end

  assign nextpc = nextpc_raw & 32'hffff_fffc;

  assign inst_sram_en    = issue;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'h0;

  assign fs_inst        = inst_buf_valid ? inst_buf : inst_sram_rdata;
  assign fs_to_ds_valid = fs_valid & ~reset;
  assign fs_to_ds_bus   = {fs_inst, fs_pc};

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid       <= 1'b0;
      fs_pc          <= RESET_PC - 32'd4;
      br_buf_valid   <= 1'b0;
      inst_buf_valid <= 1'b0;
    end else begin
      // fs_pc is kept through a stall window so seq_pc resumes correctly
      if (issue) begin
        fs_valid <= 1'b1;
        fs_pc    <= nextpc;
      end else if (fs_allowin) begin
        fs_valid <= 1'b0;
      end

      if (issue)         br_buf_valid <= 1'b0;
      else if (redirect) br_buf_valid <= 1'b1;

      if (fs_valid & ds_allowin)           inst_buf_valid <= 1'b0;
      else if (fs_valid & ~inst_buf_valid) inst_buf_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (redirect & ~issue) br_buf_target <= br_target;
    // SRAM data is only valid the cycle after the request; capture it then
    if (fs_valid & ~ds_allowin & ~inst_buf_valid) inst_buf <= inst_sram_rdata;
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a fetch-level reference model and SRAM model.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ds_allowin = 1'b1;
  logic [33:0] br_bus = 34'h0;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .ds_allowin     (ds_allowin),
    .br_bus         (br_bus),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_wen  (inst_sram_wen),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM returns the address as data after a request, garbage otherwise
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= inst_sram_addr;
    else              inst_sram_rdata <= $urandom;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which instruction is in IF, and which target is owed to fetch
  bit          m_valid   = 1'b0;
  logic [31:0] m_pc      = RST_PC - 32'd4;
  bit          m_owed    = 1'b0;
  logic [31:0] m_owed_pc = 32'h0;

  function automatic bit m_fetch();
    return !reset && (!m_valid || ds_allowin) && !br_bus[33];
  endfunction

  function automatic bit m_redirect();
    return br_bus[32] && !br_bus[33] && m_valid;
  endfunction

  function automatic logic [31:0] m_addr();
    logic [31:0] a;
    if (m_owed)            a = m_owed_pc;
    else if (m_redirect()) a = br_bus[31:0];
    else                   a = m_pc + 32'd4;
    return a & ~32'd3;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b0;
      m_pc    = RST_PC - 32'd4;
      m_owed  = 1'b0;
    end else if (m_fetch()) begin
      m_pc    = m_addr();
      m_valid = 1'b1;
      m_owed  = 1'b0;
    end else begin
      if (m_redirect()) begin
        m_owed    = 1'b1;
        m_owed_pc = br_bus[31:0];
      end
      if (ds_allowin) m_valid = 1'b0;
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!done) begin
        check("model_en", {63'h0, inst_sram_en}, {63'h0, m_fetch()});
        if (m_fetch()) check("model_addr", {32'h0, inst_sram_addr}, {32'h0, m_addr()});
        check("model_valid", {63'h0, fs_to_ds_valid}, {63'h0, (m_valid && !reset)});
        if (m_valid && !reset) check("model_bus", fs_to_ds_bus, {m_pc, m_pc});
        check("tie_wen", {60'h0, inst_sram_wen}, 64'h0);
        check("tie_wdata", {32'h0, inst_sram_wdata}, 64'h0);
      end
    end
  end

  task automatic drive(input logic r, input logic a, input logic [33:0] b);
    @(posedge clk);
    #1;
    reset = r;
    ds_allowin = a;
    br_bus = b;
    #1;
  endtask

  task automatic lit_req(input string name, input logic en, input logic [31:0] addr);
    check({name, "_en"}, {63'h0, inst_sram_en}, {63'h0, en});
    if (en) check({name, "_addr"}, {32'h0, inst_sram_addr}, {32'h0, addr});
  endtask

  task automatic lit_out(input string name, input logic v, input logic [31:0] pc);
    check({name, "_valid"}, {63'h0, fs_to_ds_valid}, {63'h0, v});
    if (v) check({name, "_bus"}, fs_to_ds_bus, {pc, pc});
  endtask

  function automatic logic [33:0] br(input logic s, input logic t, input logic [31:0] tgt);
    return {s, t, tgt};
  endfunction

  logic [15:0] allow_pat = 16'b1101_0011_1110_0101;

  initial begin
    drive(1, 1, 34'h0);
    drive(1, 1, 34'h0);
    lit_req("rst", 0, 32'h0);
    lit_out("rst", 0, 32'h0);
    // reset fetch
    drive(0, 1, 34'h0);
    lit_req("f0", 1, 32'hbfc00000);
    lit_out("f0", 0, 32'h0);
    drive(0, 1, 34'h0);
    lit_req("f1", 1, 32'hbfc00004);
    lit_out("f1", 1, 32'hbfc00000);
    // decode stall for three cycles, rdata turns to garbage
    drive(0, 0, 34'h0);
    lit_req("st0", 0, 32'h0);
    lit_out("st0", 1, 32'hbfc00004);
    drive(0, 0, 34'h0);
    drive(0, 0, 34'h0);
    lit_out("st2", 1, 32'hbfc00004);
    drive(0, 1, 34'h0);
    lit_req("resume", 1, 32'hbfc00008);
    lit_out("resume", 1, 32'hbfc00004);
    // taken branch, delay slot bfc00008 in IF
    drive(0, 1, br(0, 1, 32'hbfc00100));
    lit_req("br", 1, 32'hbfc00100);
    lit_out("br", 1, 32'hbfc00008);
    drive(0, 1, 34'h0);
    lit_req("br1", 1, 32'hbfc00104);
    lit_out("br1", 1, 32'hbfc00100);
    // unresolved branch holds fetch off, delay slot held by decode
    drive(0, 0, br(1, 1, 32'hdeadbeef));
    lit_req("bst0", 0, 32'h0);
    drive(0, 0, br(1, 1, 32'hdeadbeef));
    lit_req("bst1", 0, 32'h0);
    lit_out("bst1", 1, 32'hbfc00104);
    drive(0, 1, br(0, 1, 32'hbfc00200));
    lit_req("bst2", 1, 32'hbfc00200);
    lit_out("bst2", 1, 32'hbfc00104);
    drive(0, 1, 34'h0);
    lit_out("bst3", 1, 32'hbfc00200);
    // redirect accepted while fetch blocked goes through the branch buffer
    drive(0, 0, br(0, 1, 32'hbfc00300));
    lit_req("bb0", 0, 32'h0);
    drive(0, 1, br(0, 1, 32'hbfc00400));
    lit_req("bb1", 1, 32'hbfc00300);
    lit_out("bb1", 1, 32'hbfc00204);
    drive(0, 1, 34'h0);
    lit_req("bb2", 1, 32'hbfc00304);
    lit_out("bb2", 1, 32'hbfc00300);
    // stall with decode draining leaves IF empty
    drive(0, 1, br(1, 0, 32'h0));
    lit_req("drain", 0, 32'h0);
    // taken with IF empty is ignored
    drive(0, 1, br(0, 1, 32'hbfc00500));
    lit_req("ign", 1, 32'hbfc00308);
    lit_out("ign", 0, 32'h0);
    drive(0, 1, br(0, 1, 32'hbfc0003c));
    lit_req("ign1", 1, 32'hbfc0003c);
    drive(0, 1, 34'h0);
    lit_req("m0", 1, 32'hbfc00040);
    drive(0, 0, br(0, 1, 32'hbfc00800));
    lit_out("m1", 1, 32'hbfc00040);
    // reset mid-stream with a buffered target pending
    drive(1, 1, br(0, 1, 32'hbfc00900));
    lit_req("mrst", 0, 32'h0);
    lit_out("mrst", 0, 32'h0);
    drive(0, 1, 34'h0);
    lit_req("mrst1", 1, 32'hbfc00000);
    lit_out("mrst1", 0, 32'h0);
    drive(0, 1, 34'h0);
    lit_req("mrst2", 1, 32'hbfc00004);
    lit_out("mrst2", 1, 32'hbfc00000);
    // mixed decode backpressure, checked by the model
    for (int i = 0; i < 16; i++) drive(0, allow_pat[i], 34'h0);
    drive(0, 1, 34'h0);
    drive(0, 1, 34'h0);
    @(posedge clk);
    done = 1'b1;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
